// File: rtl/blood_unit_allocator_if.sv
// rtl/blood_unit_allocator_if.sv - load, request and response channels of the blood unit allocator
interface blood_unit_allocator_if #(
    parameter int SLOT_W = 3
);
    logic              load_valid;
    logic [SLOT_W-1:0] load_slot;
    logic              load_a;
    logic              load_b;
    logic              load_rh;
    logic              load_ready;

    logic              req_valid;
    logic              req_a;
    logic              req_b;
    logic              req_rh;
    logic              req_ready;

    logic              resp_valid;
    logic              resp_found;
    logic [SLOT_W-1:0] resp_slot;
    logic              resp_ready;

    logic [SLOT_W:0]   inv_count;

    modport master (
        output load_valid, load_slot, load_a, load_b, load_rh,
        input  load_ready,
        output req_valid, req_a, req_b, req_rh,
        input  req_ready,
        input  resp_valid, resp_found, resp_slot,
        output resp_ready,
        input  inv_count
    );

    modport slave (
        input  load_valid, load_slot, load_a, load_b, load_rh,
        output load_ready,
        input  req_valid, req_a, req_b, req_rh,
        output req_ready,
        output resp_valid, resp_found, resp_slot,
        input  resp_ready,
        output inv_count
    );
endinterface

// File: rtl/blood_unit_allocator.sv
// rtl/blood_unit_allocator.sv - first-fit ABO/Rh compatible donor unit allocator over an 8-slot inventory
module blood_unit_allocator #(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    blood_unit_allocator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [SLOTS-1:0]  slot_v;
    logic [SLOTS-1:0]  slot_a;
    logic [SLOTS-1:0]  slot_b;
    logic [SLOTS-1:0]  slot_rh;

    logic              pat_a;
    logic              pat_b;
    logic              pat_rh;
    logic [SLOT_W-1:0] scan_idx;
    logic              armed;
    logic              found_q;
    logic [SLOT_W-1:0] slot_q;

    logic              load_ready_c;
    logic              req_ready_c;
    logic              resp_valid_c;
    logic              load_fire;
    logic              req_fire;
    logic              resp_fire;
    logic              hit;
    logic              last;
    logic [SLOT_W:0]   count_c;

    // A donor antigen is acceptable only if the patient carries it too.
    assign hit = slot_v[scan_idx]
               & (~slot_a[scan_idx]  | pat_a)
               & (~slot_b[scan_idx]  | pat_b)
               & (~slot_rh[scan_idx] | pat_rh);
    assign last = (scan_idx == SLOT_W'(SLOTS - 1));

    assign load_fire = bus.load_valid & load_ready_c;
    assign req_fire  = bus.req_valid  & req_ready_c;
    assign resp_fire = resp_valid_c   & bus.resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_ready_c = 1'b0;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                load_ready_c = 1'b1;
                req_ready_c  = ~bus.load_valid;
                if (bus.req_valid && !bus.load_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (armed && (hit || last)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first SCAN cycle only arms the scanner; slot tests start the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v   <= '0;
            slot_a   <= '0;
            slot_b   <= '0;
            slot_rh  <= '0;
            pat_a    <= 1'b0;
            pat_b    <= 1'b0;
            pat_rh   <= 1'b0;
            scan_idx <= '0;
            armed    <= 1'b0;
            found_q  <= 1'b0;
            slot_q   <= '0;
        end else begin
            if (load_fire) begin
                slot_v[bus.load_slot]  <= 1'b1;
                slot_a[bus.load_slot]  <= bus.load_a;
                slot_b[bus.load_slot]  <= bus.load_b;
                slot_rh[bus.load_slot] <= bus.load_rh;
            end
            if (req_fire) begin
                pat_a    <= bus.req_a;
                pat_b    <= bus.req_b;
                pat_rh   <= bus.req_rh;
                scan_idx <= '0;
                armed    <= 1'b0;
            end
            if (state == SCAN) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else if (hit) begin
                    slot_v[scan_idx] <= 1'b0;
                    found_q          <= 1'b1;
                    slot_q           <= scan_idx;
                end else if (last) begin
                    found_q <= 1'b0;
                    slot_q  <= '0;
                end else begin
                    scan_idx <= scan_idx + SLOT_W'(1);
                end
            end
            if (resp_fire) begin
                found_q <= 1'b0;
                slot_q  <= '0;
            end
        end
    end

    always_comb begin
        count_c = '0;
        for (int i = 0; i < SLOTS; i++) begin
            count_c = count_c + (SLOT_W + 1)'(slot_v[i]);
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_found = found_q;
    assign bus.resp_slot  = slot_q;
    assign bus.inv_count  = count_c;
endmodule

// File: tb/tb_blood_unit_allocator.sv
// tb/tb_blood_unit_allocator.sv - directed vector bench for blood_unit_allocator
module tb_blood_unit_allocator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    blood_unit_allocator_if #(.SLOT_W(3)) bus ();

    blood_unit_allocator #(.SLOTS(8), .SLOT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Types are {a, b, rh}.
    typedef struct {
        logic [2:0] donor;
        logic [2:0] slot;
        logic [2:0] patient;
        logic       exp_found;
        logic [2:0] exp_slot;
        int         exp_lat;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_unit(input logic [2:0] slot, input logic [2:0] t);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_slot  = slot;
        {bus.load_a, bus.load_b, bus.load_rh} = t;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.resp_valid) break;
        end
    endtask

    task automatic send_req(input logic [2:0] t, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        {bus.req_a, bus.req_b, bus.req_rh} = t;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("consume_resp_valid", int'(bus.resp_valid), 0);
        chk("consume_load_ready", int'(bus.load_ready), 1);
    endtask

    initial begin
        int  lat;
        bit  rose;
        n_cmp = 0;
        n_bad = 0;
        bus.load_valid = 1'b0;
        bus.load_slot  = '0;
        bus.load_a     = 1'b0;
        bus.load_b     = 1'b0;
        bus.load_rh    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_a      = 1'b0;
        bus.req_b      = 1'b0;
        bus.req_rh     = 1'b0;
        bus.resp_ready = 1'b0;

        vecs[0] = '{3'b000, 3'd3, 3'b111, 1'b1, 3'd3, 5, 0};
        vecs[1] = '{3'b101, 3'd2, 3'b001, 1'b0, 3'd0, 9, 1};
        vecs[2] = '{3'b010, 3'd6, 3'b110, 1'b1, 3'd6, 8, 0};
        vecs[3] = '{3'b111, 3'd0, 3'b111, 1'b1, 3'd0, 2, 0};
        vecs[4] = '{3'b001, 3'd7, 3'b000, 1'b0, 3'd0, 9, 1};
        vecs[5] = '{3'b100, 3'd7, 3'b101, 1'b1, 3'd7, 9, 0};
        vecs[6] = '{3'b011, 3'd4, 3'b101, 1'b0, 3'd0, 9, 1};
        vecs[7] = '{3'b010, 3'd1, 3'b100, 1'b0, 3'd0, 9, 1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_found", int'(bus.resp_found), 0);
        chk("rst_resp_slot",  int'(bus.resp_slot), 0);
        chk("rst_inv_count",  int'(bus.inv_count), 0);
        chk("rst_load_ready", int'(bus.load_ready), 1);
        chk("rst_req_ready",  int'(bus.req_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            load_unit(vecs[i].slot, vecs[i].donor);
            chk($sformatf("v%0d_cnt_loaded", i), int'(bus.inv_count), 1);
            send_req(vecs[i].patient, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_found", i), int'(bus.resp_found), int'(vecs[i].exp_found));
            chk($sformatf("v%0d_slot", i), int'(bus.resp_slot), int'(vecs[i].exp_slot));
            chk($sformatf("v%0d_cnt", i), int'(bus.inv_count), vecs[i].exp_cnt);
            consume();
        end

        // First fit skips an incompatible lower slot.
        do_reset();
        load_unit(3'd0, 3'b101);
        load_unit(3'd5, 3'b000);
        chk("ff_cnt_loaded", int'(bus.inv_count), 2);
        send_req(3'b001, lat);
        chk("ff_latency", lat, 7);
        chk("ff_found", int'(bus.resp_found), 1);
        chk("ff_slot", int'(bus.resp_slot), 5);
        chk("ff_cnt", int'(bus.inv_count), 1);
        consume();

        // Overwrite of an already valid slot does not change the count.
        load_unit(3'd0, 3'b000);
        chk("ovw_cnt", int'(bus.inv_count), 1);
        send_req(3'b000, lat);
        chk("ovw_latency", lat, 2);
        chk("ovw_found", int'(bus.resp_found), 1);
        chk("ovw_slot", int'(bus.resp_slot), 0);
        consume();

        // Load and request together: load wins, request follows and sees it.
        do_reset();
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_slot  = 3'd2;
        {bus.load_a, bus.load_b, bus.load_rh} = 3'b000;
        bus.req_valid  = 1'b1;
        {bus.req_a, bus.req_b, bus.req_rh} = 3'b000;
        #1;
        chk("both_req_ready", int'(bus.req_ready), 0);
        chk("both_load_ready", int'(bus.load_ready), 1);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        #1;
        chk("both_cnt", int'(bus.inv_count), 1);
        chk("both_req_ready_next", int'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        chk("both_latency", lat, 4);
        chk("both_found", int'(bus.resp_found), 1);
        chk("both_slot", int'(bus.resp_slot), 2);
        chk("both_cnt_after", int'(bus.inv_count), 0);
        consume();

        // Back-pressure in RESP.
        do_reset();
        load_unit(3'd4, 3'b110);
        send_req(3'b111, lat);
        chk("bp_latency", lat, 6);
        @(negedge clk);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", k), int'(bus.resp_valid), 1);
            chk($sformatf("bp%0d_found", k), int'(bus.resp_found), 1);
            chk($sformatf("bp%0d_slot", k), int'(bus.resp_slot), 4);
            chk($sformatf("bp%0d_load_ready", k), int'(bus.load_ready), 0);
            chk($sformatf("bp%0d_req_ready", k), int'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        consume();

        // Reset during the third SCAN cycle aborts everything.
        do_reset();
        for (int s = 0; s < 4; s++) load_unit(3'(s), 3'b111);
        chk("abort_cnt_loaded", int'(bus.inv_count), 4);
        @(negedge clk);
        bus.req_valid = 1'b1;
        {bus.req_a, bus.req_b, bus.req_rh} = 3'b000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("abort_in_scan", int'(bus.load_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_cnt", int'(bus.inv_count), 0);
        @(negedge clk);
        rst = 1'b0;
        rose = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) rose = 1'b1;
        end
        chk("abort_no_resp", int'(rose), 0);
        chk("abort_idle_load_ready", int'(bus.load_ready), 1);
        chk("abort_idle_req_ready", int'(bus.req_ready), 1);
        chk("abort_cnt_final", int'(bus.inv_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
